// File: rtl/main_control_fsm_if.sv
// Handshake and strobe bundle between the main control FSM, the memories and the datapath.
// The FSM side is the master: it issues the memory requests and datapath strobes.
interface main_control_fsm_if;
    logic [15:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        zero;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_inc;
    logic        pc_branch;
    logic        pc_jump;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  opcode;
    logic        trap;
    logic        bus_err;

    modport master (
        input  instr, imem_ack, dmem_ack, zero,
        output imem_req, dmem_req, dmem_we, ir_we, pc_inc, pc_branch, pc_jump,
               alu_src, mem_to_reg, reg_write, alu_op, opcode, trap, bus_err
    );

    modport slave (
        output instr, imem_ack, dmem_ack, zero,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_inc, pc_branch, pc_jump,
               alu_src, mem_to_reg, reg_write, alu_op, opcode, trap, bus_err
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the 16-bit RISC core: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction/data memory and produces datapath strobes and {alu_op, opcode}.
module main_control_fsm #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    main_control_fsm_if.master  bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned OP_W  = 4;

    localparam logic [OP_W-1:0] OP_LD  = 4'h0;
    localparam logic [OP_W-1:0] OP_ST  = 4'h1;
    localparam logic [OP_W-1:0] OP_BEQ = 4'hB;
    localparam logic [OP_W-1:0] OP_BNE = 4'hC;
    localparam logic [OP_W-1:0] OP_JMP = 4'hD;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
    logic [OP_W-1:0]   opcode_d;
    logic [1:0]        alu_op_d;
    logic              pending, timeout_hit, fetch_done;
    logic              imem_req_d, dmem_req_d, dmem_we_d, pc_jump_d;
    logic              alu_src_d, mem_to_reg_d, reg_write_d, trap_d, bus_err_d;
    logic              instr_unused;

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return (op == 4'hA) || (op == 4'hE) || (op == 4'hF);
    endfunction

    function automatic logic is_rtype(input logic [OP_W-1:0] op);
        return (op >= 4'h2) && (op <= 4'h9);
    endfunction

    function automatic logic is_ldst(input logic [OP_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic [1:0] alu_class(input logic [OP_W-1:0] op);
        if (is_ldst(op))
            return 2'b10;
        else if ((op == OP_BEQ) || (op == OP_BNE))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Only the opcode field of the instruction word is decoded here.
    assign instr_unused = ^bus.instr[11:0];

    // IR load and PC increment coincide with the accepted fetch handshake.
    assign fetch_done    = (state == S_FETCH) && bus.imem_req && bus.imem_ack;
    assign bus.ir_we     = fetch_done;
    assign bus.pc_inc    = fetch_done;
    assign bus.pc_branch = (state == S_EXEC) &&
                           (((bus.opcode == OP_BEQ) && bus.zero) ||
                            ((bus.opcode == OP_BNE) && !bus.zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_FETCH;
            wait_cnt       <= '0;
            bus.imem_req   <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.pc_jump    <= 1'b0;
            bus.alu_src    <= 1'b0;
            bus.mem_to_reg <= 1'b0;
            bus.reg_write  <= 1'b0;
            bus.alu_op     <= 2'b00;
            bus.opcode     <= '0;
            bus.trap       <= 1'b0;
            bus.bus_err    <= 1'b0;
        end else begin
            state          <= next_state;
            wait_cnt       <= wait_cnt_d;
            bus.imem_req   <= imem_req_d;
            bus.dmem_req   <= dmem_req_d;
            bus.dmem_we    <= dmem_we_d;
            bus.pc_jump    <= pc_jump_d;
            bus.alu_src    <= alu_src_d;
            bus.mem_to_reg <= mem_to_reg_d;
            bus.reg_write  <= reg_write_d;
            bus.alu_op     <= alu_op_d;
            bus.opcode     <= opcode_d;
            bus.trap       <= trap_d;
            bus.bus_err    <= bus_err_d;
        end
    end

    // Next state, wait counter, and the registered outputs decoded from the next state/opcode.
    always_comb begin
        next_state   = state;
        opcode_d     = bus.opcode;
        bus_err_d    = bus.bus_err;
        pending      = 1'b0;

        case (state)
            S_FETCH: begin
                pending = bus.imem_req && !bus.imem_ack;
                if (fetch_done) begin
                    next_state = S_DECODE;
                    opcode_d   = bus.instr[15:12];
                end
            end
            S_DECODE: begin
                if (is_illegal(bus.opcode))
                    next_state = S_TRAP;
                else if (bus.opcode == OP_JMP)
                    next_state = S_FETCH;
                else
                    next_state = S_EXEC;
            end
            S_EXEC: begin
                if (is_ldst(bus.opcode))
                    next_state = S_MEM;
                else if (is_rtype(bus.opcode))
                    next_state = S_WB;
                else
                    next_state = S_FETCH;
            end
            S_MEM: begin
                pending = bus.dmem_req && !bus.dmem_ack;
                if (bus.dmem_req && bus.dmem_ack)
                    next_state = (bus.opcode == OP_ST) ? S_FETCH : S_WB;
            end
            S_WB:    next_state = S_FETCH;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase

        // An ack in the final allowed wait cycle is handled above and never reaches here.
        timeout_hit = pending && (wait_cnt == CNT_W'(TIMEOUT - 1));
        if (timeout_hit) begin
            next_state = S_TRAP;
            bus_err_d  = 1'b1;
        end

        if (next_state != state)
            wait_cnt_d = '0;
        else if (pending)
            wait_cnt_d = wait_cnt + CNT_W'(1);
        else
            wait_cnt_d = wait_cnt;

        imem_req_d   = (next_state == S_FETCH);
        dmem_req_d   = (next_state == S_MEM);
        dmem_we_d    = (next_state == S_MEM) && (opcode_d == OP_ST);
        alu_src_d    = ((next_state == S_EXEC) && is_ldst(opcode_d)) || (next_state == S_MEM);
        mem_to_reg_d = (next_state == S_WB) && (opcode_d == OP_LD);
        reg_write_d  = (next_state == S_WB);
        pc_jump_d    = (next_state == S_DECODE) && (opcode_d == OP_JMP);
        trap_d       = bus.trap || (next_state == S_TRAP);
        alu_op_d     = (next_state inside {S_EXEC, S_MEM, S_WB}) ? alu_class(opcode_d) : 2'b00;
    end
endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-cycle checks of every output against hand-derived vectors.
module tb_main_control_fsm;
    logic clk;
    logic rst_n;

    main_control_fsm_if bus ();

    main_control_fsm #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [11:0] IREQ = 12'h800;
    localparam logic [11:0] DREQ = 12'h400;
    localparam logic [11:0] DWE  = 12'h200;
    localparam logic [11:0] IRWE = 12'h100;
    localparam logic [11:0] PCI  = 12'h080;
    localparam logic [11:0] PCB  = 12'h040;
    localparam logic [11:0] PCJ  = 12'h020;
    localparam logic [11:0] ASRC = 12'h010;
    localparam logic [11:0] M2R  = 12'h008;
    localparam logic [11:0] REGW = 12'h004;
    localparam logic [11:0] TRP  = 12'h002;
    localparam logic [11:0] BERR = 12'h001;
    localparam logic [11:0] FACK = IREQ | IRWE | PCI;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] sample_outs();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_inc, bus.pc_branch,
                bus.pc_jump, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.trap, bus.bus_err,
                bus.alu_op, bus.opcode};
    endfunction

    // Let inputs settle, then compare {strobes, alu_op, opcode} for the current cycle.
    task automatic expect_st(input string tag, input logic [11:0] s, input logic [1:0] a,
                             input logic [3:0] op);
        logic [17:0] e;
        e = {s, a, op};
        #1;
        chk(tag, 32'(sample_outs()), 32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Ends inside the first FETCH cycle with imem_req asserted.
    task automatic reset_dut();
        bus.instr    = 16'h0000;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.zero     = 1'b0;
        rst_n        = 1'b0;
        expect_st("in_reset", 12'h000, 2'b00, 4'h0);
        tick();
        rst_n = 1'b1;
        expect_st("rst_release", 12'h000, 2'b00, 4'h0);
        tick();
        expect_st("rst_fetch", IREQ, 2'b00, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] br_instr [4];
        logic        br_zero  [4];
        logic [11:0] br_exp   [4];
        logic [3:0]  prev_op;
        logic [3:0]  cur_op;

        rst_n        = 1'b0;
        bus.instr    = 16'h0000;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.zero     = 1'b0;
        @(posedge clk);
        #2;
        reset_dut();

        // ADD: 4 cycles, reg_write only in WB
        bus.instr = 16'h2123; bus.imem_ack = 1'b1;
        expect_st("add_fetch", FACK, 2'b00, 4'h0);
        tick(); bus.imem_ack = 1'b0;
        expect_st("add_decode", 12'h000, 2'b00, 4'h2);
        tick(); expect_st("add_exec", 12'h000, 2'b00, 4'h2);
        tick(); expect_st("add_wb", REGW, 2'b00, 4'h2);
        tick(); expect_st("add_next_fetch", IREQ, 2'b00, 4'h2);

        // LD with two data wait states
        bus.instr = 16'h0456; bus.imem_ack = 1'b1;
        expect_st("ld_fetch", FACK, 2'b00, 4'h2);
        tick(); bus.imem_ack = 1'b0;
        expect_st("ld_decode", 12'h000, 2'b00, 4'h0);
        tick(); expect_st("ld_exec", ASRC, 2'b10, 4'h0);
        tick(); expect_st("ld_mem_wait1", DREQ | ASRC, 2'b10, 4'h0);
        tick(); expect_st("ld_mem_wait2", DREQ | ASRC, 2'b10, 4'h0);
        tick(); bus.dmem_ack = 1'b1;
        expect_st("ld_mem_ack", DREQ | ASRC, 2'b10, 4'h0);
        tick(); bus.dmem_ack = 1'b0;
        expect_st("ld_wb", REGW | M2R, 2'b10, 4'h0);
        tick(); expect_st("ld_next_fetch", IREQ, 2'b00, 4'h0);

        // ST zero-wait: 4 cycles, dmem_we with dmem_req
        bus.instr = 16'h1234; bus.imem_ack = 1'b1;
        expect_st("st_fetch", FACK, 2'b00, 4'h0);
        tick(); bus.imem_ack = 1'b0;
        expect_st("st_decode", 12'h000, 2'b00, 4'h1);
        tick(); expect_st("st_exec", ASRC, 2'b10, 4'h1);
        tick(); bus.dmem_ack = 1'b1;
        expect_st("st_mem", DREQ | DWE | ASRC, 2'b10, 4'h1);
        tick(); bus.dmem_ack = 1'b0;
        expect_st("st_next_fetch", IREQ, 2'b00, 4'h1);

        // Branches: {instr, zero, expected EXEC strobes}
        br_instr[0] = 16'hB001; br_zero[0] = 1'b1; br_exp[0] = PCB;
        br_instr[1] = 16'hB001; br_zero[1] = 1'b0; br_exp[1] = 12'h000;
        br_instr[2] = 16'hC001; br_zero[2] = 1'b0; br_exp[2] = PCB;
        br_instr[3] = 16'hC001; br_zero[3] = 1'b1; br_exp[3] = 12'h000;
        prev_op = 4'h1;
        for (int i = 0; i < 4; i++) begin
            cur_op = br_instr[i][15:12];
            bus.instr = br_instr[i]; bus.imem_ack = 1'b1;
            expect_st($sformatf("br%0d_fetch", i), FACK, 2'b00, prev_op);
            tick(); bus.imem_ack = 1'b0;
            expect_st($sformatf("br%0d_decode", i), 12'h000, 2'b00, cur_op);
            tick(); bus.zero = br_zero[i];
            expect_st($sformatf("br%0d_exec", i), br_exp[i], 2'b01, cur_op);
            tick(); bus.zero = 1'b0;
            expect_st($sformatf("br%0d_next_fetch", i), IREQ, 2'b00, cur_op);
            prev_op = cur_op;
        end

        // JMP: 2 cycles, pc_jump in DECODE
        bus.instr = 16'hD000; bus.imem_ack = 1'b1;
        expect_st("jmp_fetch", FACK, 2'b00, 4'hC);
        tick(); bus.imem_ack = 1'b0;
        expect_st("jmp_decode", PCJ, 2'b00, 4'hD);
        tick(); expect_st("jmp_next_fetch", IREQ, 2'b00, 4'hD);

        // Fetch ack arriving on the 15th wait cycle still wins
        for (int i = 1; i < 15; i++) begin
            expect_st($sformatf("late_ack_wait%0d", i), IREQ, 2'b00, 4'hD);
            tick();
        end
        bus.instr = 16'h2000; bus.imem_ack = 1'b1;
        expect_st("late_ack_c15", FACK, 2'b00, 4'hD);
        tick(); bus.imem_ack = 1'b0;
        expect_st("late_ack_decode", 12'h000, 2'b00, 4'h2);
        tick(); expect_st("late_ack_exec", 12'h000, 2'b00, 4'h2);
        tick(); expect_st("late_ack_wb", REGW, 2'b00, 4'h2);
        tick(); expect_st("late_ack_fetch", IREQ, 2'b00, 4'h2);

        // Reset in the middle of a stalled ST; a later dmem_ack must be ignored
        bus.instr = 16'h1000; bus.imem_ack = 1'b1;
        expect_st("mid_fetch", FACK, 2'b00, 4'h2);
        tick(); bus.imem_ack = 1'b0;
        expect_st("mid_decode", 12'h000, 2'b00, 4'h1);
        tick(); expect_st("mid_exec", ASRC, 2'b10, 4'h1);
        tick(); expect_st("mid_mem", DREQ | DWE | ASRC, 2'b10, 4'h1);
        rst_n = 1'b0;
        expect_st("mid_in_reset", 12'h000, 2'b00, 4'h0);
        tick(); rst_n = 1'b1; bus.dmem_ack = 1'b1;
        expect_st("mid_post_reset", 12'h000, 2'b00, 4'h0);
        tick(); expect_st("mid_fetch_req", IREQ, 2'b00, 4'h0);
        tick(); expect_st("mid_dack_ignored", IREQ, 2'b00, 4'h0);
        bus.dmem_ack = 1'b0;

        // Fetch timeout: 15 unanswered cycles -> TRAP with bus_err
        reset_dut();
        for (int i = 1; i <= 15; i++) begin
            expect_st($sformatf("ftmo_wait%0d", i), IREQ, 2'b00, 4'h0);
            tick();
        end
        expect_st("ftmo_trap", TRP | BERR, 2'b00, 4'h0);
        tick(); bus.imem_ack = 1'b1;
        expect_st("ftmo_trap_hold", TRP | BERR, 2'b00, 4'h0);

        // Illegal opcode: TRAP without bus_err, no fetch for 50 cycles
        reset_dut();
        bus.instr = 16'hE000; bus.imem_ack = 1'b1;
        expect_st("ill_fetch", FACK, 2'b00, 4'h0);
        tick(); expect_st("ill_decode", 12'h000, 2'b00, 4'hE);
        for (int i = 0; i < 50; i++) begin
            tick();
            expect_st($sformatf("ill_trap%0d", i), TRP, 2'b00, 4'hE);
        end

        // Data-side timeout during LD
        reset_dut();
        bus.instr = 16'h0000; bus.imem_ack = 1'b1;
        expect_st("dtmo_fetch", FACK, 2'b00, 4'h0);
        tick(); bus.imem_ack = 1'b0;
        expect_st("dtmo_decode", 12'h000, 2'b00, 4'h0);
        tick(); expect_st("dtmo_exec", ASRC, 2'b10, 4'h0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            expect_st($sformatf("dtmo_wait%0d", i), DREQ | ASRC, 2'b10, 4'h0);
        end
        tick(); expect_st("dtmo_trap", TRP | BERR, 2'b00, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
